pulse_sync_rx: RTL and testbench



---
 rtl/pulse_sync_rx.sv | 130 +++++++++++++
 tb/tb_pulse_sync_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_rx.sv
// pulse_sync_rx: destination-side receiver for toggle-encoded events crossing into clkdest.
// Each channel is synchronised, strobed on pulse_dest and queued in a saturating pending counter.
module pulse_sync_rx #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = 0
) (
  input  logic                      clkdest,
  input  logic                      resetb_clkdest,
  input  logic [CHANNELS-1:0]       tog_async,
  output logic [CHANNELS-1:0]       pulse_dest,
  output logic [CHANNELS-1:0]       evt_valid,
  input  logic [CHANNELS-1:0]       evt_ready,
  output logic [CHANNELS*CNT_W-1:0] evt_pending,
  output logic [CHANNELS-1:0]       overflow,
  input  logic [CHANNELS-1:0]       clr_overflow,
  output logic                      armed
);

  localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_r;
  logic [CHANNELS-1:0]                  hist_r;
  logic [ARM_W-1:0]                     arm_cnt_r;
  logic                                 armed_r;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_r;
  logic [CHANNELS-1:0]                  evt_valid_r;
  logic [CHANNELS-1:0]                  overflow_r;

  logic [CHANNELS-1:0]                  sync_q_s;
  logic [CHANNELS-1:0]                  raw_edge_s;
  logic [CHANNELS-1:0]                  pulse_s;
  logic [CHANNELS-1:0]                  inc_s;
  logic [CHANNELS-1:0]                  dec_s;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_nxt_s;
  logic [CHANNELS-1:0]                  ovf_nxt_s;
  logic [CHANNELS-1:0]                  valid_nxt_s;

  // Synchroniser chains and the edge-history flop behind each chain
  always_ff @(posedge clkdest or negedge resetb_clkdest) begin
    if (!resetb_clkdest) begin
      sync_r <= '0;
      hist_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], tog_async[i]};
      end
      hist_r <= sync_q_s;
    end
  end

  // Post-reset arming: blocks edges caused by input levels present at reset release
  always_ff @(posedge clkdest or negedge resetb_clkdest) begin
    if (!resetb_clkdest) begin
      arm_cnt_r <= '0;
      armed_r   <= 1'b0;
    end else if (!armed_r) begin
      if (arm_cnt_r == ARM_LAST) begin
        armed_r <= 1'b1;
      end else begin
        arm_cnt_r <= arm_cnt_r + ARM_ONE;
      end
    end else begin
      armed_r <= 1'b1;
    end
  end

  // Edge detection on the synchronised level, gated by arming
  always_comb begin
    sync_q_s   = '0;
    raw_edge_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_q_s[i] = sync_r[i][SYNC_STAGES-1];
    end
    if (EDGE_MODE == 32'sd0) begin
      raw_edge_s = sync_q_s ^ hist_r;
    end else begin
      raw_edge_s = sync_q_s & ~hist_r;
    end
    pulse_s = raw_edge_s & {CHANNELS{armed_r}};
  end

  // Pending counter next state; simultaneous event and accept cancel out
  always_comb begin
    inc_s       = pulse_s;
    dec_s       = evt_valid_r & evt_ready;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = overflow_r & ~clr_overflow;
    valid_nxt_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case ({inc_s[i], dec_s[i]})
        2'b10: begin
          if (cnt_r[i] == CNT_MAX) begin
            ovf_nxt_s[i] = 1'b1;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        2'b01:   cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase
      valid_nxt_s[i] = (cnt_nxt_s[i] != {CNT_W{1'b0}});
    end
  end

  // Pending counters, valid flags and sticky overflow
  always_ff @(posedge clkdest or negedge resetb_clkdest) begin
    if (!resetb_clkdest) begin
      cnt_r       <= '0;
      evt_valid_r <= '0;
      overflow_r  <= '0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      evt_valid_r <= valid_nxt_s;
      overflow_r  <= ovf_nxt_s;
    end
  end

  assign pulse_dest  = pulse_s;
  assign evt_valid   = evt_valid_r;
  assign evt_pending = cnt_r;
  assign overflow    = overflow_r;
  assign armed       = armed_r;

endmodule

// File: tb/tb_pulse_sync_rx.sv
// Randomised scoreboard bench for pulse_sync_rx: one instance per edge mode, shared stimulus,
// expected pulse cycles queued at stimulus time and checked by a negedge monitor.
module tb_pulse_sync_rx;
  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clkdest = 1'b0;
  logic            resetb_clkdest = 1'b1;
  logic [CH-1:0]   tog_async = '0;
  logic [CH-1:0]   evt_ready = '0;
  logic [CH-1:0]   clr_overflow = '0;
  logic [CH-1:0]   pulse0, valid0, ovf0, pulse1, valid1, ovf1;
  logic [CH*CW-1:0] pend0, pend1;
  logic            armed0, armed1;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int last_rst = 0;
  int pq [2*CH][$];
  int last_chg [CH];
  int mcnt [2][CH];
  bit movf [2][CH];

  pulse_sync_rx #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW), .EDGE_MODE(0)) dut0 (
    .clkdest(clkdest), .resetb_clkdest(resetb_clkdest), .tog_async(tog_async),
    .pulse_dest(pulse0), .evt_valid(valid0), .evt_ready(evt_ready), .evt_pending(pend0),
    .overflow(ovf0), .clr_overflow(clr_overflow), .armed(armed0));

  pulse_sync_rx #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW), .EDGE_MODE(1)) dut1 (
    .clkdest(clkdest), .resetb_clkdest(resetb_clkdest), .tog_async(tog_async),
    .pulse_dest(pulse1), .evt_valid(valid1), .evt_ready(evt_ready), .evt_pending(pend1),
    .overflow(ovf1), .clr_overflow(clr_overflow), .armed(armed1));

  always #5 clkdest = ~clkdest;

  always @(posedge clkdest) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop due pulses, compare every output, then advance the event-count model
  always @(negedge clkdest) begin
    logic [CH-1:0]    ep, ev, eo;
    logic [CH*CW-1:0] ecnt;
    logic             ea;
    ea = resetb_clkdest && (cyc >= last_rst + SS + 2);
    for (int m = 0; m < 2; m++) begin
      ep = '0; ev = '0; eo = '0; ecnt = '0;
      if (!resetb_clkdest) begin
        for (int c = 0; c < CH; c++) begin
          mcnt[m][c] = 0;
          movf[m][c] = 1'b0;
        end
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (pq[m*CH+c].size() > 0 && pq[m*CH+c][0] == cyc) begin
            ep[c] = ea;
            void'(pq[m*CH+c].pop_front());
          end
        end
      end
      for (int c = 0; c < CH; c++) begin
        ev[c] = (mcnt[m][c] > 0);
        eo[c] = movf[m][c];
        ecnt[c*CW +: CW] = CW'(mcnt[m][c]);
      end
      if (m == 0) begin
        chk("pulse_dest_m0", 64'(pulse0), 64'(ep));
        chk("evt_valid_m0", 64'(valid0), 64'(ev));
        chk("evt_pending_m0", 64'(pend0), 64'(ecnt));
        chk("overflow_m0", 64'(ovf0), 64'(eo));
        chk("armed_m0", 64'(armed0), 64'(ea));
      end else begin
        chk("pulse_dest_m1", 64'(pulse1), 64'(ep));
        chk("evt_valid_m1", 64'(valid1), 64'(ev));
        chk("evt_pending_m1", 64'(pend1), 64'(ecnt));
        chk("overflow_m1", 64'(ovf1), 64'(eo));
        chk("armed_m1", 64'(armed1), 64'(ea));
      end
      if (resetb_clkdest) begin
        for (int c = 0; c < CH; c++) begin
          bit inc, dec, set;
          inc = ep[c];
          dec = (mcnt[m][c] > 0) && evt_ready[c];
          set = 1'b0;
          if (inc && !dec) begin
            if (mcnt[m][c] == CMAX) set = 1'b1;
            else mcnt[m][c]++;
          end else if (dec && !inc) begin
            mcnt[m][c]--;
          end
          movf[m][c] = set ? 1'b1 : (clr_overflow[c] ? 1'b0 : movf[m][c]);
        end
      end
    end
    if (!resetb_clkdest) last_rst = cyc;
  end

  task automatic step();
    @(posedge clkdest);
    #1;
  endtask

  task automatic push_evt(input int c, input logic lvl);
    pq[c].push_back(cyc + SS);
    if (lvl) pq[CH+c].push_back(cyc + SS);
  endtask

  task automatic set_tog(input logic [CH-1:0] nt);
    for (int c = 0; c < CH; c++) begin
      if (nt[c] != tog_async[c]) begin
        if (resetb_clkdest) push_evt(c, nt[c]);
        last_chg[c] = cyc;
      end
    end
    tog_async = nt;
  endtask

  task automatic do_reset(input int hold);
    resetb_clkdest = 1'b0;
    for (int i = 0; i < 2*CH; i++) pq[i].delete();
    repeat (hold) step();
    resetb_clkdest = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if (tog_async[c]) push_evt(c, 1'b1);
      last_chg[c] = cyc;
    end
  endtask

  task automatic run(input int n, input int p_tog, input int p_rdy, input int p_clr);
    logic [CH-1:0] nt;
    repeat (n) begin
      step();
      nt = tog_async;
      for (int c = 0; c < CH; c++) begin
        if ((cyc - last_chg[c]) >= 2 && $urandom_range(99) < p_tog) nt[c] = ~nt[c];
        evt_ready[c]    = ($urandom_range(99) < p_rdy);
        clr_overflow[c] = ($urandom_range(99) < p_clr);
      end
      set_tog(nt);
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) last_chg[c] = 0;
    tog_async = {CH{1'b1}};
    #1;
    do_reset(3);
    run(10, 0, 0, 0);
    run(80, 45, 0, 0);
    run(20, 20, 0, 30);
    run(150, 30, 50, 5);
    run(25, 40, 0, 0);
    do_reset(2);
    run(10, 0, 0, 0);
    run(150, 40, 60, 5);
    run(40, 0, 100, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
